counter_sched: RTL and testbench

Shares one 4-bit enable/reset counter (clk, active-high reset, enable, count out, overflow out) between NREQ requesters. Each requester asks for a run of LEN enable ticks. The block arbitrates round-robin, clears the counter, enables it for exactly LEN cycles, then checks the final count and overflow against expectation. It reports done, requester id and error flag, and sits between requester FSMs and the shared counter instance.

---
 rtl/counter_sched_pkg.sv | 26 ++
 rtl/counter_sched_if.sv | 46 ++++
 rtl/counter_sched_rr_arbiter.sv | 36 +++
 rtl/counter_sched.sv | 139 +++++++++++++
 tb/tb_counter_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM state type, default widths and the
// expected-result helpers used when a counter run is checked.
package counter_sched_pkg;

  localparam int DEF_CW    = 4;
  localparam int DEF_LEN_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Count a cw-bit counter shows after len enabled ticks from zero.
  function automatic int unsigned exp_count(input int unsigned len, input int unsigned cw);
    return len % (32'd1 << cw);
  endfunction

  // Whether len enabled ticks from zero wrap a cw-bit counter.
  function automatic logic exp_ovf(input int unsigned len, input int unsigned cw);
    return (len >= (32'd1 << cw));
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// counter_sched_if: requester handshake plus shared-counter control bundle.
// slave modport is the scheduler side, master modport the environment
// (requesters and the shared counter instance). The abort signal exists
// only when COUNTER_SCHED_ABORT_EN is defined.
interface counter_sched_if #(
  parameter int NREQ  = 2,
  parameter int CW    = 4,
  parameter int LEN_W = 5
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  err;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [CW-1:0]         cnt_val;
  logic                  cnt_ovf;
`ifdef COUNTER_SCHED_ABORT_EN
  logic                  abort;

  modport slave (
    input  req, len, cnt_val, cnt_ovf, abort,
    output gnt, done, done_id, err, cnt_clr, cnt_en
  );

  modport master (
    output req, len, cnt_val, cnt_ovf, abort,
    input  gnt, done, done_id, err, cnt_clr, cnt_en
  );
`else
  modport slave (
    input  req, len, cnt_val, cnt_ovf,
    output gnt, done, done_id, err, cnt_clr, cnt_en
  );

  modport master (
    output req, len, cnt_val, cnt_ovf,
    input  gnt, done, done_id, err, cnt_clr, cnt_en
  );
`endif

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Selects the first set req
// bit at or after ptr, wrapping; the pointer itself lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [31:0]    idx;
  logic [IDW-1:0] sel;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        id       = sel;
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: shares one CW-bit enable/reset counter between NREQ
// requesters. Round-robin grant, clear, enable for LEN cycles, then check
// count and overflow and report done/done_id/err.
// Optional: COUNTER_SCHED_ABORT_EN adds an abort input that ends a run
// from CLEAR or RUN straight into DONE with err set.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CW    = DEF_CW,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic            clk,
  input  logic            reset_n,
  counter_sched_if.slave  bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] tick_q, tick_d;
  logic             ovf_seen_q, ovf_seen_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  logic [CW-1:0]    chk_cnt;
  logic             chk_ovf;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  // Expected result for the latched run length.
  always_comb begin
    chk_cnt = CW'(exp_count(32'(len_q), CW));
    chk_ovf = exp_ovf(32'(len_q), CW);
  end

  // Next-state and datapath updates for the run sequencer.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    tick_d     = tick_q;
    ovf_seen_d = ovf_seen_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          id_d  = arb_id;
          gnt_d = arb_gnt;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_id == IDW'(i)) len_d = bus.len[i*LEN_W +: LEN_W];
          end
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tick_d     = '0;
        ovf_seen_d = 1'b0;
        err_d      = 1'b0;
        state_d    = (len_q != '0) ? ST_RUN : ST_CHECK;
      end
      ST_RUN: begin
        if (bus.cnt_ovf) ovf_seen_d = 1'b1;
        tick_d = tick_q + LEN_W'(1);
        if (tick_q == len_q - LEN_W'(1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // An overflow arriving in this very cycle still counts.
        ovf_seen_d = ovf_seen_q | bus.cnt_ovf;
        err_d      = (bus.cnt_val != chk_cnt) || (ovf_seen_d != chk_ovf);
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef COUNTER_SCHED_ABORT_EN
    if (bus.abort && (state_q == ST_CLEAR || state_q == ST_RUN)) begin
      err_d   = 1'b1;
      state_d = ST_DONE;
    end
`endif
  end

  // State and datapath registers; reset drops any run in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      len_q      <= '0;
      tick_q     <= '0;
      ovf_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      tick_q     <= tick_d;
      ovf_seen_q <= ovf_seen_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = (state_q == ST_DONE);
  assign bus.done_id = (state_q == ST_DONE) ? id_q : '0;
  assign bus.err     = (state_q == ST_DONE) & err_q;
  assign bus.cnt_clr = (state_q == ST_CLEAR);
  assign bus.cnt_en  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: scoreboard bench for counter_sched with a behavioural
// shared counter. Define COUNTER_SCHED_ABORT_EN to also exercise abort.
module tb_counter_sched;

  localparam int NREQ   = 2;
  localparam int CW     = 4;
  localparam int LEN_W  = 5;
  localparam int MAXLEN = (1 << LEN_W) - 1;
  localparam int CMOD   = 1 << CW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  counter_sched_if #(.NREQ(NREQ), .CW(CW), .LEN_W(LEN_W)) bus ();

  counter_sched #(.NREQ(NREQ), .CW(CW), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Shared counter: synchronous clear, overflow pulse after wrapping.
  logic [CW-1:0] ctr;
  logic          ctr_ovf;
  logic          stuck = 1'b0;
  always @(posedge clk) begin
    if (!reset_n || bus.cnt_clr) begin
      ctr     <= '0;
      ctr_ovf <= 1'b0;
    end else if (bus.cnt_en) begin
      ctr     <= ctr + 1'b1;
      ctr_ovf <= (ctr == {CW{1'b1}});
    end else begin
      ctr_ovf <= 1'b0;
    end
  end
  assign bus.cnt_val = stuck ? '0 : ctr;
  assign bus.cnt_ovf = stuck ? 1'b0 : ctr_ovf;

  typedef struct {
    int unsigned id;
    int unsigned en;
    int unsigned lat;
    int unsigned cnt;
    int unsigned err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned ptr_m   = 0;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned lens[NREQ];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
  endtask

  function automatic int unsigned pick(input logic [NREQ-1:0] m, input int unsigned p);
    for (int unsigned k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // Reference result for one complete run of ln ticks.
  task automatic push_run(input int unsigned id, input int unsigned ln, input bit stk);
    exp_t e;
    e.id  = id;
    e.en  = ln;
    e.lat = ln + 3;
    if (stk) begin
      e.cnt = 0;
      e.err = ((ln % CMOD) != 0 || ln >= CMOD) ? 1 : 0;
    end else begin
      e.cnt = ln % CMOD;
      e.err = 0;
    end
    sbq.push_back(e);
  endtask

  // Monitor: counts grant/clear/enable cycles per run, checks at done.
  int unsigned g_cyc = 0, en_cyc = 0, clr_cyc = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      g_cyc = 0; en_cyc = 0; clr_cyc = 0;
    end else begin
      if (bus.gnt != '0) begin
        g_cyc++;
        if (bus.cnt_en)  en_cyc++;
        if (bus.cnt_clr) clr_cyc++;
      end else begin
        g_cyc = 0; en_cyc = 0; clr_cyc = 0;
      end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_id", 32'(bus.done_id), mon_e.id);
          chk("err", 32'(bus.err), mon_e.err);
          chk("gnt_onehot", 32'(bus.gnt), 32'd1 << mon_e.id);
          chk("en_cycles", en_cyc, mon_e.en);
          chk("clr_cycles", clr_cyc, 1);
          chk("latency", g_cyc, mon_e.lat);
          chk("cnt_val", 32'(bus.cnt_val), mon_e.cnt);
        end
      end
    end
  end

  task automatic drive_lens();
    for (int unsigned i = 0; i < NREQ; i++) bus.len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Raise mask together; each requester drops once its grant shows.
  task automatic run_batch(input logic [NREQ-1:0] mask, input bit stk);
    logic [NREQ-1:0] m;
    int unsigned id;
    int unsigned n = 0;
    m = mask;
    while (m != '0) begin
      id = pick(m, ptr_m);
      push_run(id, lens[id], stk);
      m[id] = 1'b0;
      ptr_m = (id + 1) % NREQ;
    end
    @(posedge clk); #1;
    stuck = stk;
    drive_lens();
    bus.req = mask;
    while (bus.req != '0 && n < 300) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~bus.gnt;
      n++;
    end
    if (bus.req != '0) begin
      chk("grant_timeout", 32'(bus.req), 0);
      bus.req = '0;
    end
    wait_drain(300);
    stuck = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] prev;
    int unsigned n, seen, grants, id;

    bus.req = '0;
    bus.len = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_done_id", 32'(bus.done_id), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cnt_clr", 32'(bus.cnt_clr), 0);
    chk("rst_cnt_en", 32'(bus.cnt_en), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    ptr_m = 0;
    repeat (2) @(posedge clk);

    // Directed runs: no wrap, wrap, just below wrap, zero length, stuck counter.
    lens[0] = 10; lens[1] = 0; run_batch(2'b01, 1'b0);
    lens[0] = 20; run_batch(2'b01, 1'b0);
    lens[0] = 15; run_batch(2'b01, 1'b0);
    lens[0] = 0;  run_batch(2'b01, 1'b0);
    lens[0] = 7;  run_batch(2'b01, 1'b1);
    lens[0] = 16; run_batch(2'b01, 1'b0);

    // Reset in the middle of a run: outputs clear at once, no done.
    lens[0] = 20;
    @(posedge clk); #1;
    drive_lens();
    bus.req = 2'b01;
    n = 0; seen = 0;
    while (seen < 5 && n < 100) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~bus.gnt;
      if (bus.cnt_en) seen++;
      n++;
    end
    chk("pre_rst_run_en", 32'(bus.cnt_en), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    chk("mid_rst_cnt_clr", 32'(bus.cnt_clr), 0);
    chk("mid_rst_cnt_en", 32'(bus.cnt_en), 0);
    bus.req = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    ptr_m = 0;
    repeat (3) @(posedge clk);

    // Both requesters held high: grants must alternate from requester 0.
    lens[0] = 3; lens[1] = 5;
    for (int k = 0; k < 4; k++) begin
      id = pick(2'b11, ptr_m);
      push_run(id, lens[id], 1'b0);
      ptr_m = (id + 1) % NREQ;
    end
    @(posedge clk); #1;
    drive_lens();
    bus.req = '1;
    prev = '0; grants = 0; n = 0;
    while (grants < 4 && n < 300) begin
      @(posedge clk); #1;
      if (bus.gnt != '0 && prev == '0) grants++;
      prev = bus.gnt;
      n++;
    end
    bus.req = '0;
    if (grants < 4) chk("hold_grants", grants, 4);
    wait_drain(300);

`ifdef COUNTER_SCHED_ABORT_EN
    // Abort during the 4th enabled cycle of a 10-tick run.
    begin
      exp_t e;
      lens[0] = 10;
      e.id = pick(2'b01, ptr_m); e.en = 4; e.lat = 6; e.cnt = 4; e.err = 1;
      sbq.push_back(e);
      ptr_m = (e.id + 1) % NREQ;
      @(posedge clk); #1;
      drive_lens();
      bus.req = 2'b01;
      n = 0; seen = 0;
      while (seen < 4 && n < 100) begin
        @(posedge clk); #1;
        bus.req = bus.req & ~bus.gnt;
        if (bus.cnt_en) seen++;
        n++;
      end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_en_low", 32'(bus.cnt_en), 0);
      wait_drain(100);
    end
`endif

    // Randomised batches, biased toward boundary lengths.
    for (int t = 0; t < 30; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int unsigned i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 5))
          0:       lens[i] = 0;
          1:       lens[i] = CMOD - 1;
          2:       lens[i] = CMOD;
          3:       lens[i] = MAXLEN;
          default: lens[i] = $urandom_range(0, MAXLEN);
        endcase
      end
      run_batch(mask, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
